alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Sequences one data-processing instruction at a time through the shared ALU: evaluates the ARM condition field against the NZCV register.
//  Drives the ALU opcode and operands, captures result and flags, and presents a write-back beat to the register file.
//  Owns the architectural NZCV flags. Sits between the decode stage (request side) and the register file (write-back side).
// PARAMETERS
//  DATA_W  32  operand/result width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous reset, active-high
//  in_valid     in   1       instruction request valid
//  in_ready     out  1       block can accept request
//  in_opcode    in   4       ALU opcode (0000 AND .. 1111 MVN, standard DP encoding)
//  in_cond      in   4       ARM condition field
//  in_s         in   1       set-flags bit
//  in_rd        in   4       destination register index
//  in_a         in   DATA_W  operand A (Rn)
//  in_b         in   DATA_W  operand B (shifted operand 2)
//  in_shc       in   1       shifter carry-out for operand B
//  alu_op       out  4       opcode to ALU decoder
//  alu_a        out  DATA_W  operand A to ALU
//  alu_b        out  DATA_W  operand B to ALU
//  alu_cin      out  1       current C flag to ALU
//  alu_res      in   DATA_W  ALU result (combinational from alu_*)
//  alu_nzcv     in   4       ALU flag outputs {N,Z,C,V}
//  wb_valid     out  1       write-back beat valid
//  wb_ready     in   1       register file accepts beat
//  wb_we        out  1       1 = write wb_data to wb_rd; 0 = completion only
//  wb_rd        out  4       destination index
//  wb_data      out  DATA_W  result
//  flags        out  4       architectural {N,Z,C,V}
// BEHAVIOUR
//  FSM IDLE -> EXEC -> RESP -> IDLE. in_ready = (state==IDLE).
//  IDLE: on in_valid, latch all in_* fields into holding registers; go to EXEC.
//  EXEC (exactly 1 cycle): alu_op/a/b come from holding registers; alu_cin = flags[1].
//   Evaluate cond against flags: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z,
//   GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 never.
//   Pass: register wb_data=alu_res; wb_we=1 unless opcode is 10xx (TST/TEQ/CMP/CMN).
//   Flags update if (pass & (in_s | opcode 10xx)):
//    arithmetic (0010-0111, 1010, 1011): NZCV <= alu_nzcv.
//    logical (all others): N,Z <= alu_nzcv[3:2]; C <= in_shc; V unchanged.
//   Fail: wb_we=0, wb_data unchanged, flags unchanged. Go to RESP in both cases.
//  RESP: wb_valid=1, wb_rd/wb_we/wb_data stable until wb_ready; on wb_valid&wb_ready go to IDLE.
//  Latency: accept at cycle t, wb_valid at t+2; max throughput one instruction per 3 cycles.
//  Flag update is visible on flags at t+2, so the next instruction's cond and alu_cin see it.
//  alu_* outputs hold their last values outside EXEC.
//  Reset (any state, incl. mid-EXEC/RESP): state IDLE, flags 4'b0000, wb_valid 0, wb_we 0, wb_rd 0, wb_data 0,
//   holding registers 0. A pending beat is dropped, with no flag side effect in that cycle.
//  in_valid while not IDLE is ignored (not latched). wb_ready outside RESP is ignored.
// TESTING
//  Reset, then ADD S=1 cond=AL a=0xFFFFFFFF b=1 -> wb at t+2: we=1 data=0, flags=0110.
//  CMP cond=AL a=5 b=5 -> wb_we=0, flags Z=1,C=1. Next MOV cond=NE -> wb_we=0, flags unchanged.
//  ADC after flag C=1, a=1 b=1 -> alu_cin=1 in EXEC, data=3. Logical ANDS with in_shc=1 -> C=1, V preserved.
//  Hold wb_ready=0 for 5 cycles in RESP -> wb_valid/wb_data stable, in_ready=0, second in_valid not latched.
//  Assert rst during RESP with flags=1111 -> next cycle wb_valid=0, flags=0000, in_ready=1.
//  cond=1111 with S=1 and CMP -> no flag change, wb_we=0, wb_valid still pulses.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issues one ARM data-processing op through the shared ALU, gates it on the condition field, owns NZCV.
// Latency: accept -> wb_valid two cycles later; the write-back beat holds until wb_ready, in_ready is low while busy.
module alu_issue_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_cond,
  input  logic              in_s,
  input  logic [3:0]        in_rd,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_shc,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [3:0]        alu_nzcv,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [3:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [3:0]        cond;
    logic              s;
    logic [3:0]        rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              shc;
  } hold_t;

  state_t state;
  hold_t  hold;
  logic   cin_q;
  logic   cond_pass;
  logic   is_cmp;
  logic   is_arith;
  logic   flag_upd;

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return cf;
      4'h3:    return !cf;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return cf && !z;
      4'h9:    return !cf || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    cond_pass = eval_cond(hold.cond, flags);
    is_cmp    = (hold.opcode[3:2] == 2'b10);
    is_arith  = hold.opcode inside {[4'd2:4'd7], 4'd10, 4'd11};
    flag_upd  = cond_pass && (hold.s || is_cmp);
  end

  assign in_ready = (state == IDLE);
  assign alu_op   = hold.opcode;
  assign alu_a    = hold.a;
  assign alu_b    = hold.b;
  // Outside EXEC the carry presented to the ALU must not follow a flag update made by that same op.
  assign alu_cin  = (state == EXEC) ? flags[1] : cin_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= '0;
      cin_q    <= 1'b0;
      flags    <= 4'b0000;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= 4'd0;
      wb_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold <= '{opcode: in_opcode, cond: in_cond, s: in_s, rd: in_rd,
                      a: in_a, b: in_b, shc: in_shc};
            state <= EXEC;
          end
        end
        EXEC: begin
          cin_q    <= flags[1];
          wb_rd    <= hold.rd;
          wb_valid <= 1'b1;
          state    <= RESP;
          if (cond_pass) begin
            wb_data <= alu_res;
            wb_we   <= !is_cmp;
          end else begin
            wb_we   <= 1'b0;
          end
          if (flag_upd) begin
            if (is_arith) flags <= alu_nzcv;
            else          flags <= {alu_nzcv[3:2], hold.shc, flags[0]};
          end
        end
        RESP: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
